// File: rtl/exception_entry_controller_pkg.sv
// exception_entry_controller_pkg: shared modes, vector offsets, CPSR bit indices and FSM states
package exception_entry_controller_pkg;
   localparam int WordWidth = 32;
   localparam logic [WordWidth-1:0] WordZero = '0;
   localparam logic [4:0] MODE_USER = 5'b10000;
   localparam logic [4:0] MODE_FIQ  = 5'b10001;
   localparam logic [4:0] MODE_IRQ  = 5'b10010;
   localparam logic [4:0] MODE_SVC  = 5'b10011;
   localparam logic [4:0] MODE_ABT  = 5'b10111;
   localparam logic [4:0] MODE_UND  = 5'b11011;
   localparam logic [7:0] VEC_UND  = 8'h04;
   localparam logic [7:0] VEC_SWI  = 8'h08;
   localparam logic [7:0] VEC_PABT = 8'h0C;
   localparam logic [7:0] VEC_DABT = 8'h10;
   localparam logic [7:0] VEC_IRQ  = 8'h18;
   localparam logic [7:0] VEC_FIQ  = 8'h1C;
   localparam int CPSR_I = 7;
   localparam int CPSR_F = 6;
   localparam int CPSR_T = 5;
   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT, ST_VECTOR} state_t;
endpackage

// File: rtl/exception_entry_controller_if.sv
// exception_entry_controller_if: request/status bundle; in_HighVectors exists only with EXC_HIGH_VECTORS_EN
interface exception_entry_controller_if
   import exception_entry_controller_pkg::*;
#(
   parameter int WORD_WIDTH = WordWidth
);
   logic                  in_FIQ;
   logic                  in_IRQ;
   logic                  in_DataAbort;
   logic                  in_PrefetchAbort;
   logic                  in_Undefined;
   logic                  in_SWI;
   logic [WORD_WIDTH-1:0] in_ExceptionPC;
   logic [WORD_WIDTH-1:0] in_NextPC;
   logic [WORD_WIDTH-1:0] in_CPSR;
   logic                  in_PipelineDrained;
   logic                  in_VectorAccept;
`ifdef EXC_HIGH_VECTORS_EN
   logic                  in_HighVectors;
`endif
   logic                  out_IfChangeState;
   logic [4:0]            out_ChangeStateAction;
   logic [WORD_WIDTH-1:0] out_CPSRWriteValue;
   logic                  out_SPSRWriteEnable;
   logic [WORD_WIDTH-1:0] out_SPSRWriteValue;
   logic                  out_Flush;
   logic [WORD_WIDTH-1:0] out_LinkValue;
   logic                  out_LinkWrite;
   logic                  out_VectorValid;
   logic [WORD_WIDTH-1:0] out_VectorAddress;
   logic                  out_Busy;
   modport slave (
      input  in_FIQ, in_IRQ, in_DataAbort, in_PrefetchAbort, in_Undefined, in_SWI,
      input  in_ExceptionPC, in_NextPC, in_CPSR, in_PipelineDrained, in_VectorAccept,
`ifdef EXC_HIGH_VECTORS_EN
      input  in_HighVectors,
`endif
      output out_IfChangeState, out_ChangeStateAction, out_CPSRWriteValue,
      output out_SPSRWriteEnable, out_SPSRWriteValue, out_Flush, out_LinkValue,
      output out_LinkWrite, out_VectorValid, out_VectorAddress, out_Busy
   );
   modport master (
      output in_FIQ, in_IRQ, in_DataAbort, in_PrefetchAbort, in_Undefined, in_SWI,
      output in_ExceptionPC, in_NextPC, in_CPSR, in_PipelineDrained, in_VectorAccept,
`ifdef EXC_HIGH_VECTORS_EN
      output in_HighVectors,
`endif
      input  out_IfChangeState, out_ChangeStateAction, out_CPSRWriteValue,
      input  out_SPSRWriteEnable, out_SPSRWriteValue, out_Flush, out_LinkValue,
      input  out_LinkWrite, out_VectorValid, out_VectorAddress, out_Busy
   );
endinterface

// File: rtl/exception_entry_controller_priority_encoder.sv
// exception_priority_encoder: picks the winning exception and its mode, vector offset and return link
module exception_priority_encoder
   import exception_entry_controller_pkg::*;
#(
   parameter int WORD_WIDTH = WordWidth
) (
   input  logic                  data_abort_i,
   input  logic                  fiq_i,
   input  logic                  irq_i,
   input  logic                  prefetch_abort_i,
   input  logic                  undefined_i,
   input  logic                  swi_i,
   input  logic [WORD_WIDTH-1:0] exception_pc_i,
   input  logic [WORD_WIDTH-1:0] next_pc_i,
   output logic                  valid_o,
   output logic                  fiq_o,
   output logic [4:0]            mode_o,
   output logic [7:0]            offset_o,
   output logic [WORD_WIDTH-1:0] link_o
);
   // Fixed priority DABT > FIQ > IRQ > PABT > UND > SWI
   always_comb begin
      valid_o  = data_abort_i | fiq_i | irq_i | prefetch_abort_i | undefined_i | swi_i;
      fiq_o    = ~data_abort_i & fiq_i;
      mode_o   = data_abort_i ? MODE_ABT : fiq_i ? MODE_FIQ : irq_i ? MODE_IRQ :
                 prefetch_abort_i ? MODE_ABT : undefined_i ? MODE_UND : MODE_SVC;
      offset_o = data_abort_i ? VEC_DABT : fiq_i ? VEC_FIQ : irq_i ? VEC_IRQ :
                 prefetch_abort_i ? VEC_PABT : undefined_i ? VEC_UND : VEC_SWI;
      link_o   = data_abort_i ? exception_pc_i + WORD_WIDTH'(8) :
                 (fiq_i | irq_i) ? next_pc_i + WORD_WIDTH'(4) : exception_pc_i + WORD_WIDTH'(4);
   end
endmodule

// File: rtl/exception_entry_controller.sv
// exception_entry_controller: sequences ARM exception entry (flush, commit, vector); EXC_HIGH_VECTORS_EN adds high vectors
module exception_entry_controller
   import exception_entry_controller_pkg::*;
#(
   parameter int                    WORD_WIDTH  = WordWidth,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [WORD_WIDTH-1:0] VECTOR_BASE = '0
) (
   input logic clock,
   input logic reset,
   exception_entry_controller_if.slave bus
);
   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  fiq_sync_q, irq_sync_q;
   logic [4:0]              mode_q;
   logic                    fiq_q;
   logic [WORD_WIDTH-1:0]   spsr_q, link_q, vec_q;
   logic                    fiq_req, irq_req, pe_valid, pe_fiq, capture;
   logic [4:0]              pe_mode;
   logic [7:0]              pe_offset;
   logic [WORD_WIDTH-1:0]   pe_link, base;

   assign fiq_req = fiq_sync_q[SYNC_STAGES-1] & ~bus.in_CPSR[CPSR_F];
   assign irq_req = irq_sync_q[SYNC_STAGES-1] & ~bus.in_CPSR[CPSR_I];
   assign capture = (state_q == ST_IDLE) && pe_valid;
`ifdef EXC_HIGH_VECTORS_EN
   assign base = bus.in_HighVectors ? WORD_WIDTH'(32'hFFFF_0000) : VECTOR_BASE;
`else
   assign base = VECTOR_BASE;
`endif

   exception_priority_encoder #(.WORD_WIDTH(WORD_WIDTH)) u_prio (
      .data_abort_i     (bus.in_DataAbort),
      .fiq_i            (fiq_req),
      .irq_i            (irq_req),
      .prefetch_abort_i (bus.in_PrefetchAbort),
      .undefined_i      (bus.in_Undefined),
      .swi_i            (bus.in_SWI),
      .exception_pc_i   (bus.in_ExceptionPC),
      .next_pc_i        (bus.in_NextPC),
      .valid_o          (pe_valid),
      .fiq_o            (pe_fiq),
      .mode_o           (pe_mode),
      .offset_o         (pe_offset),
      .link_o           (pe_link)
   );

   // Bring the asynchronous interrupt levels into the clock domain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fiq_sync_q <= '0;
         irq_sync_q <= '0;
      end else begin
         fiq_sync_q <= {fiq_sync_q[SYNC_STAGES-2:0], bus.in_FIQ};
         irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.in_IRQ};
      end
   end

   // State register plus snapshot of the winning exception taken in IDLE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= '0;
         fiq_q   <= 1'b0;
         spsr_q  <= '0;
         link_q  <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            mode_q <= pe_mode;
            fiq_q  <= pe_fiq;
            spsr_q <= bus.in_CPSR;
            link_q <= pe_link;
            vec_q  <= base + WORD_WIDTH'(pe_offset);
         end
      end
   end

   // Next state and state-decoded outputs; data outputs are zero outside their phase
   always_comb begin
      state_d                   = state_q;
      bus.out_IfChangeState     = state_q == ST_COMMIT;
      bus.out_SPSRWriteEnable   = state_q == ST_COMMIT;
      bus.out_LinkWrite         = state_q == ST_COMMIT;
      bus.out_ChangeStateAction = (state_q == ST_COMMIT) ? mode_q : '0;
      bus.out_SPSRWriteValue    = (state_q == ST_COMMIT) ? spsr_q : '0;
      bus.out_LinkValue         = (state_q == ST_COMMIT) ? link_q : '0;
      bus.out_CPSRWriteValue    = (state_q == ST_COMMIT) ?
                                  {spsr_q[WORD_WIDTH-1:CPSR_I+1], 1'b1, fiq_q | spsr_q[CPSR_F], 1'b0, mode_q} : '0;
      bus.out_Flush             = state_q == ST_FLUSH;
      bus.out_VectorValid       = state_q == ST_VECTOR;
      bus.out_VectorAddress     = (state_q == ST_VECTOR) ? vec_q : '0;
      bus.out_Busy              = state_q != ST_IDLE;
      case (state_q)
         ST_IDLE:   if (pe_valid) state_d = ST_FLUSH;
         ST_FLUSH:  if (bus.in_PipelineDrained) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_VECTOR;
         ST_VECTOR: if (bus.in_VectorAccept) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_exception_entry_controller.sv
// tb_exception_entry_controller: table vectors, hand sequences and randomized trials against a priority-list model
module tb_exception_entry_controller;
   localparam logic [31:0] VB = 32'h0;

   typedef struct {
      logic [4:0]  mode;
      logic [31:0] cpsr, spsr, link, vec;
   } exp_t;

   typedef struct {
      logic [5:0]  req;
      logic [31:0] epc, cpsr;
      int          drain, acc;
      logic [4:0]  mode;
      logic [31:0] ncpsr, link, vec;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   // priority order index: 0 DABT, 1 FIQ, 2 IRQ, 3 PABT, 4 UND, 5 SWI
   logic [4:0]  ref_mode [6] = '{5'b10111, 5'b10001, 5'b10010, 5'b10111, 5'b11011, 5'b10011};
   logic [31:0] ref_off  [6] = '{32'h10, 32'h1C, 32'h18, 32'h0C, 32'h04, 32'h08};

   exception_entry_controller_if #(.WORD_WIDTH(32)) bus ();

   exception_entry_controller #(.WORD_WIDTH(32), .SYNC_STAGES(2), .VECTOR_BASE(VB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   function automatic exp_t model(logic [5:0] req, logic [31:0] epc, logic [31:0] npc, logic [31:0] cpsr);
      exp_t e;
      e = '{default: '0};
      for (int k = 0; k < 6; k++) begin
         if (req[k]) begin
            e.mode = ref_mode[k];
            e.vec  = VB + ref_off[k];
            e.link = (k == 0) ? epc + 32'd8 : (k == 1 || k == 2) ? npc + 32'd4 : epc + 32'd4;
            e.spsr = cpsr;
            e.cpsr = {cpsr[31:8], 1'b1, (k == 1) ? 1'b1 : cpsr[6], 1'b0, ref_mode[k]};
            return e;
         end
      end
      return e;
   endfunction

   function automatic logic any_out();
      return |{bus.out_IfChangeState, bus.out_ChangeStateAction, bus.out_CPSRWriteValue,
               bus.out_SPSRWriteEnable, bus.out_SPSRWriteValue, bus.out_Flush, bus.out_LinkValue,
               bus.out_LinkWrite, bus.out_VectorValid, bus.out_VectorAddress, bus.out_Busy};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wait_flush(input int bound, output int lat);
      lat = 0;
      while (!bus.out_Flush && lat < bound) begin
         step();
         lat++;
      end
      chk("flush_seen", bus.out_Flush, 1);
   endtask

   task automatic apply_sync(input logic [5:0] req, input logic [31:0] epc, input logic [31:0] cpsr);
      int lat;
      bus.in_ExceptionPC   = epc;
      bus.in_CPSR          = cpsr;
      bus.in_DataAbort     = req[0];
      bus.in_PrefetchAbort = req[3];
      bus.in_Undefined     = req[4];
      bus.in_SWI           = req[5];
      step();
      bus.in_DataAbort     = 0;
      bus.in_PrefetchAbort = 0;
      bus.in_Undefined     = 0;
      bus.in_SWI           = 0;
      wait_flush(0, lat);
   endtask

   task automatic expect_entry(input exp_t e, input int drain, input int acc);
      int fl, early, bad;
      fl = 0;
      early = 0;
      bad = 0;
      while (bus.out_Flush && fl < 64) begin
         bus.in_PipelineDrained = (fl >= drain);
         early += int'(bus.out_IfChangeState | bus.out_SPSRWriteEnable | bus.out_LinkWrite);
         fl++;
         step();
      end
      bus.in_PipelineDrained = 0;
      chk("flush_len", fl, drain + 1);
      chk("early_strobe", early, 0);
      chk("commit_strobes", {bus.out_IfChangeState, bus.out_SPSRWriteEnable, bus.out_LinkWrite}, 3'b111);
      chk("action", bus.out_ChangeStateAction, e.mode);
      chk("cpsr_write", bus.out_CPSRWriteValue, e.cpsr);
      chk("spsr_write", bus.out_SPSRWriteValue, e.spsr);
      chk("link", bus.out_LinkValue, e.link);
      step();
      chk("commit_once", bus.out_IfChangeState, 0);
      for (int i = 0; i < acc; i++) begin
         bad += int'(bus.out_VectorValid !== 1'b1 || bus.out_VectorAddress !== e.vec);
         step();
      end
      chk("vec_stable", bad, 0);
      chk("vec_valid", bus.out_VectorValid, 1);
      chk("vec_addr", bus.out_VectorAddress, e.vec);
      bus.in_VectorAccept = 1;
      step();
      bus.in_VectorAccept = 0;
      chk("vec_drop", {bus.out_VectorValid, bus.out_Busy}, 0);
   endtask

   vec_t tbl [6];

   initial begin
      int lat, cnt;
      logic [5:0] req;
      logic [31:0] epc, cpsr, npc;
      exp_t e;
      tbl[0] = '{6'b100000, 32'h100,      32'h10,       0, 0, 5'b10011, 32'h93,       32'h104,  32'h08};
      tbl[1] = '{6'b010001, 32'h200,      32'h10,       1, 2, 5'b10111, 32'h97,       32'h208,  32'h10};
      tbl[2] = '{6'b101000, 32'h300,      32'h1F,       0, 1, 5'b10111, 32'h97,       32'h304,  32'h0C};
      tbl[3] = '{6'b010000, 32'hFFFFFFFC, 32'hF000005F, 5, 3, 5'b11011, 32'hF00000DB, 32'h0,    32'h04};
      tbl[4] = '{6'b100000, 32'h1000,     32'h30,       2, 0, 5'b10011, 32'h93,       32'h1004, 32'h08};
      tbl[5] = '{6'b000001, 32'hFFFFFFF8, 32'h3F,       0, 0, 5'b10111, 32'h97,       32'h0,    32'h10};
      bus.in_FIQ = 0; bus.in_IRQ = 0; bus.in_DataAbort = 0; bus.in_PrefetchAbort = 0;
      bus.in_Undefined = 0; bus.in_SWI = 0; bus.in_ExceptionPC = 0; bus.in_NextPC = 32'h4000;
      bus.in_CPSR = 32'h10; bus.in_PipelineDrained = 0; bus.in_VectorAccept = 0;
`ifdef EXC_HIGH_VECTORS_EN
      bus.in_HighVectors = 0;
`endif
      step();
      step();
      chk("reset_outputs", any_out(), 0);
      reset = 0;
      step();
      chk("idle_after_reset", any_out(), 0);

      for (int i = 0; i < 6; i++) begin
         apply_sync(tbl[i].req, tbl[i].epc, tbl[i].cpsr);
         e = '{tbl[i].mode, tbl[i].ncpsr, tbl[i].cpsr, tbl[i].link, tbl[i].vec};
         expect_entry(e, tbl[i].drain, tbl[i].acc);
         step();
      end

      // FIQ beats IRQ
      bus.in_CPSR = 32'h10;
      bus.in_NextPC = 32'h4000;
      bus.in_FIQ = 1;
      bus.in_IRQ = 1;
      wait_flush(8, lat);
      bus.in_FIQ = 0;
      bus.in_IRQ = 0;
      expect_entry('{5'b10001, 32'hD1, 32'h10, 32'h4004, 32'h1C}, 0, 0);
      repeat (3) step();

      // masked IRQ, then unmask
      bus.in_CPSR = 32'h90;
      bus.in_IRQ = 1;
      cnt = 0;
      repeat (6) begin
         cnt += int'(bus.out_Busy);
         step();
      end
      chk("irq_masked_busy", cnt, 0);
      bus.in_CPSR = 32'h10;
      wait_flush(8, lat);
      chk("irq_unmask_latency_ok", lat <= 3, 1);
      bus.in_CPSR = 32'h92;
      expect_entry('{5'b10010, 32'h92, 32'h10, 32'h4004, 32'h18}, 1, 1);
      cnt = 0;
      repeat (6) begin
         cnt += int'(bus.out_Busy);
         step();
      end
      chk("irq_blocked_after_entry", cnt, 0);
      bus.in_FIQ = 1;
      wait_flush(8, lat);
      bus.in_FIQ = 0;
      bus.in_IRQ = 0;
      expect_entry('{5'b10001, 32'hD1, 32'h92, 32'h4004, 32'h1C}, 0, 0);
      bus.in_CPSR = 32'h10;
      repeat (3) step();

      // sync pulses outside IDLE are ignored
      apply_sync(6'b100000, 32'h700, 32'h10);
      bus.in_Undefined = 1;
      expect_entry('{5'b10011, 32'h93, 32'h10, 32'h704, 32'h08}, 2, 1);
      bus.in_Undefined = 0;
      step();
      chk("pulse_ignored_busy", bus.out_Busy, 0);

      // reset during FLUSH
      apply_sync(6'b100000, 32'h500, 32'h10);
      step();
      step();
      #3 reset = 1;
      #1;
      chk("reset_mid_flush", any_out(), 0);
      bus.in_PipelineDrained = 1;
      step();
      reset = 0;
      cnt = 0;
      repeat (6) begin
         cnt += int'(bus.out_IfChangeState | bus.out_Busy);
         step();
      end
      bus.in_PipelineDrained = 0;
      chk("no_strobe_after_reset", cnt, 0);

      // randomized synchronous exceptions
      for (int t = 0; t < 30; t++) begin
         req = 6'($urandom) & 6'b111001;
         if (req == 0) req = 6'b100000;
         epc = $urandom;
         cpsr = $urandom;
         e = model(req, epc, 32'h4000, cpsr);
         apply_sync(req, epc, cpsr);
         expect_entry(e, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         step();
      end

      // randomized interrupts against CPSR masks
      for (int t = 0; t < 20; t++) begin
         cpsr = $urandom;
         npc = $urandom;
         bus.in_CPSR = cpsr;
         bus.in_NextPC = npc;
         bus.in_FIQ = 1'($urandom);
         bus.in_IRQ = 1'($urandom);
         req = {3'b000, bus.in_IRQ & ~cpsr[7], bus.in_FIQ & ~cpsr[6], 1'b0};
         if (req == 0) begin
            cnt = 0;
            repeat (6) begin
               cnt += int'(bus.out_Busy);
               step();
            end
            chk("rand_masked_idle", cnt, 0);
         end else begin
            wait_flush(8, lat);
            bus.in_FIQ = 0;
            bus.in_IRQ = 0;
            expect_entry(model(req, 32'h0, npc, cpsr), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
         bus.in_FIQ = 0;
         bus.in_IRQ = 0;
         repeat (3) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
